// File: rtl/pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline control blocks.
package pipe_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned WAIT_CNT_W = 16;

  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LEGv8 pipeline: load-use stalls,
// MEM-resolved branch flushes, memory-wait freeze, timeout flag and statistics.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] id_rn,
  input  logic [REG_IDX_W-1:0] id_rm,
  input  logic                 id_uses_rn,
  input  logic                 id_uses_rm,
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 mem_branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_write,
  output logic                 exmem_write,
  output logic                 memwb_write,
  output logic                 idex_bubble,
  output logic                 ifid_flush,
  output logic                 exmem_flush,
  output logic                 mem_wait,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  state_t                  state;
  state_t                  state_nxt;
  logic                    hazard;
  logic                    freeze;
  logic                    stall_inc;
  logic                    flush_inc;
  logic [WAIT_CNT_W-1:0]   wait_cnt;

  // XZR reads as zero, so a load targeting it can never feed a consumer.
  assign hazard = ex_memread && (ex_rd != XZR_IDX) &&
                  ((id_uses_rn && (id_rn == ex_rd)) ||
                   (id_uses_rm && (id_rm == ex_rd)));
  assign freeze = dmem_req && !dmem_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = RUN;
    if (freeze) begin
      state_nxt = WAIT;
    end
  end

  // Priority: reset > freeze > branch > load-use hazard > normal.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    mem_wait    = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      mem_wait    = 1'b1;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Timeout tracking; the freeze itself is never broken by the timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (state == WAIT) begin
      if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end
      if (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT)) begin
        mem_err <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  assign stall_inc = freeze || (hazard && !mem_branch_taken);
  assign flush_inc = !freeze && mem_branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (stall_inc),
    .clear   (1'b0),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (flush_inc),
    .clear   (1'b0),
    .count   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_memread;
  logic       mem_branch_taken, dmem_req, dmem_ready;
  logic       pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic       idex_bubble, ifid_flush, exmem_flush, mem_wait, mem_err;
  logic [1:0] stall_cnt, flush_cnt;
  logic [8:0] ctrl;

  int checks = 0;
  int fails  = 0;

  // {pc,ifid,idex,exmem,memwb write, ifid_flush, idex_bubble, exmem_flush, mem_wait}
  localparam logic [8:0] C_NORMAL = 9'b11111_000_0;
  localparam logic [8:0] C_STALL  = 9'b00111_010_0;
  localparam logic [8:0] C_BRANCH = 9'b11111_111_0;
  localparam logic [8:0] C_FREEZE = 9'b00000_000_1;
  localparam logic [8:0] C_RESET  = 9'b00000_111_0;

  assign ctrl = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                 ifid_flush, idex_bubble, exmem_flush, mem_wait};

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .exmem_flush(exmem_flush), .mem_wait(mem_wait),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic set_idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; mem_branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    set_idle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_idle();
    #2;
    checks++; if (ctrl !== C_RESET) begin fails++; $display("FAIL reset_ctrl got %b exp %b", ctrl, C_RESET); end
    checks++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_mem_err got %b exp 0", mem_err); end
    checks++; if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin fails++; $display("FAIL post_reset_ctrl got %b exp %b", ctrl, C_NORMAL); end
  endtask

  task automatic test_load_use();
    apply_reset();
    @(negedge clock);
    ex_memread = 1'b1; ex_rd = 5'd1; id_rn = 5'd1; id_uses_rn = 1'b1; id_rm = 5'd2; id_uses_rm = 1'b0;
    #1;
    checks++; if (ctrl !== C_STALL) begin fails++; $display("FAIL load_use_rn got %b exp %b", ctrl, C_STALL); end
    @(negedge clock);
    checks++; if (stall_cnt !== 2'd1) begin fails++; $display("FAIL load_use_cnt got %0d exp 1", stall_cnt); end
    ex_memread = 1'b0;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin fails++; $display("FAIL load_use_next got %b exp %b", ctrl, C_NORMAL); end
    @(negedge clock);
    ex_memread = 1'b1; ex_rd = 5'd2;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin fails++; $display("FAIL rm_unused got %b exp %b", ctrl, C_NORMAL); end
    @(negedge clock);
    checks++; if (stall_cnt !== 2'd1) begin fails++; $display("FAIL rm_unused_cnt got %0d exp 1", stall_cnt); end
    id_uses_rm = 1'b1;
    #1;
    checks++; if (ctrl !== C_STALL) begin fails++; $display("FAIL load_use_rm got %b exp %b", ctrl, C_STALL); end
    @(negedge clock);
    checks++; if (stall_cnt !== 2'd2) begin fails++; $display("FAIL load_use_rm_cnt got %0d exp 2", stall_cnt); end
    set_idle();
  endtask

  task automatic test_xzr();
    apply_reset();
    @(negedge clock);
    ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_uses_rn = 1'b1; id_rm = 5'd31; id_uses_rm = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin fails++; $display("FAIL xzr_ctrl got %b exp %b", ctrl, C_NORMAL); end
    @(negedge clock);
    checks++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL xzr_cnt got %0d exp 0", stall_cnt); end
    set_idle();
  endtask

  task automatic test_branch_hazard();
    apply_reset();
    @(negedge clock);
    ex_memread = 1'b1; ex_rd = 5'd4; id_rn = 5'd4; id_uses_rn = 1'b1; mem_branch_taken = 1'b1;
    #1;
    checks++; if (ctrl !== C_BRANCH) begin fails++; $display("FAIL branch_hazard_ctrl got %b exp %b", ctrl, C_BRANCH); end
    @(negedge clock);
    checks++; if (flush_cnt !== 2'd1 || stall_cnt !== 2'd0) begin fails++; $display("FAIL branch_hazard_cnt got flush=%0d stall=%0d exp 1/0", flush_cnt, stall_cnt); end
    set_idle();
  endtask

  task automatic test_freeze();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      #1;
      checks++; if (ctrl !== C_FREEZE) begin fails++; $display("FAIL freeze_ctrl cycle %0d got %b exp %b", k, ctrl, C_FREEZE); end
    end
    @(negedge clock);
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin fails++; $display("FAIL freeze_release got %b exp %b", ctrl, C_NORMAL); end
    @(negedge clock);
    checks++; if (stall_cnt !== 2'd3) begin fails++; $display("FAIL freeze_cnt got %0d exp 3", stall_cnt); end
    set_idle();
  endtask

  task automatic test_freeze_branch();
    apply_reset();
    @(negedge clock);
    dmem_req = 1'b1; dmem_ready = 1'b0; mem_branch_taken = 1'b1;
    #1;
    checks++; if (ctrl !== C_FREEZE) begin fails++; $display("FAIL freeze_branch_ctrl got %b exp %b", ctrl, C_FREEZE); end
    @(negedge clock);
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_BRANCH) begin fails++; $display("FAIL freeze_branch_release got %b exp %b", ctrl, C_BRANCH); end
    @(negedge clock);
    checks++; if (flush_cnt !== 2'd1 || stall_cnt !== 2'd1) begin fails++; $display("FAIL freeze_branch_cnt got flush=%0d stall=%0d exp 1/1", flush_cnt, stall_cnt); end
    set_idle();
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      dmem_req = 1'b1; dmem_ready = 1'b0;
      if (k == 6) begin
        checks++; if (mem_err !== 1'b0) begin fails++; $display("FAIL timeout_early got %b exp 0", mem_err); end
      end
      if (k == 7) begin
        checks++; if (mem_err !== 1'b1) begin fails++; $display("FAIL timeout_set got %b exp 1", mem_err); end
      end
      if (k == 10) begin
        #1;
        checks++; if (ctrl !== C_FREEZE) begin fails++; $display("FAIL timeout_still_frozen got %b exp %b", ctrl, C_FREEZE); end
      end
    end
    @(negedge clock);
    dmem_ready = 1'b1;
    @(negedge clock);
    set_idle();
    checks++; if (mem_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got %b exp 1", mem_err); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_err !== 1'b0) begin fails++; $display("FAIL timeout_reset_clear got %b exp 0", mem_err); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      dmem_req = 1'b1; dmem_ready = 1'b0;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ctrl !== C_RESET) begin fails++; $display("FAIL mid_wait_reset_ctrl got %b exp %b", ctrl, C_RESET); end
    checks++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL mid_wait_reset_cnt got %0d exp 0", stall_cnt); end
    @(negedge clock);
    set_idle();
    reset_n = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin fails++; $display("FAIL mid_wait_after got %b exp %b", ctrl, C_NORMAL); end
    // wait_cnt must restart from zero: 5 WAIT cycles needed again before mem_err
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      dmem_req = 1'b1; dmem_ready = 1'b0;
    end
    checks++; if (mem_err !== 1'b0) begin fails++; $display("FAIL mid_wait_wait_cnt got %b exp 0", mem_err); end
    @(negedge clock);
    set_idle();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      ex_memread = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_uses_rm = 1'b1;
    end
    @(negedge clock);
    set_idle();
    checks++; if (stall_cnt !== 2'd3) begin fails++; $display("FAIL stall_saturate got %0d exp 3", stall_cnt); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      mem_branch_taken = 1'b1;
    end
    @(negedge clock);
    set_idle();
    checks++; if (flush_cnt !== 2'd3) begin fails++; $display("FAIL flush_saturate got %0d exp 3", flush_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_xzr();
    test_branch_hazard();
    test_freeze();
    test_freeze_branch();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage LEGv8 pipeline. It owns the write enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and taken branches resolved in MEM, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters
- MEM_TIMEOUT, 255, wait cycles after which mem_err sets (1..2^16-1)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_rn, id_rm  in  5 each  source registers of the instruction in ID
- id_uses_rn, id_uses_rm  in  1 each  ID instruction actually reads that source
- ex_memread  in  1  ID/EX Memread (instruction in EX is a load)
- ex_rd  in  5  ID/EX write_reg
- mem_branch_taken  in  1  branch resolved taken in MEM
- dmem_req  in  1  MEM stage issuing a data-memory access this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  register load enables
- idex_bubble  out  1  load zeros into ID/EX control fields
- ifid_flush, exmem_flush  out  1 each  squash IF/ID instruction / EX/MEM control fields
- mem_wait  out  1  pipeline frozen on memory
- mem_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  CNT_W each  statistics

## Operation
- States: RUN, WAIT. Encoded in a 1-bit register.
- hazard = ex_memread & ex_rd != 31 & ((id_uses_rn & id_rn == ex_rd) | (id_uses_rm & id_rm == ex_rd)). Register 31 (XZR) never causes a hazard.
- freeze = dmem_req & !dmem_ready, in either state.
- Priority, evaluated each cycle: freeze > mem_branch_taken > hazard > normal.
- freeze:
  - All five write enables are 0.
  - All flush/bubble outputs are 0.
  - mem_wait is 1.
  - Next state is WAIT.
- Branch:
  - All write enables are 1.
  - ifid_flush, idex_bubble and exmem_flush are 1. This squashes the three younger instructions.
  - The PC loads the branch target (PC mux handled externally).
- Hazard:
  - pc_write and ifid_write are 0.
  - idex_write is 1 and idex_bubble is 1.
  - exmem_write and memwb_write are 1.
- Normal: all write enables are 1; all flush/bubble outputs are 0.
- WAIT → RUN when freeze is 0. That cycle is evaluated with normal priority, so a pending branch or hazard is acted on then.
- Timeout:
  - wait_cnt is 16 bits. It increments in WAIT and clears on RUN.
  - When wait_cnt == MEM_TIMEOUT, mem_err sets. It clears only on reset.
  - The freeze continues after the timeout.
- Counters:
  - stall_cnt increments on every cycle with freeze or hazard (hazard cycles counted when not superseded by a branch).
  - flush_cnt increments once per branch cycle.
  - Both counters saturate at all-ones.

## Timing
- All control outputs are combinational from the inputs and state. They are valid in the same cycle, with zero latency.
- State, wait_cnt, mem_err and the counters update on the rising clock edge.
- While reset_n = 0:
  - All write enables are 0.
  - ifid_flush, idex_bubble and exmem_flush are 1.
  - mem_wait is 0, mem_err is 0, and the counters are 0.
  - State is RUN.
- Reset mid-WAIT returns to RUN immediately and clears wait_cnt; mem_err ends at 0.
- A load-use stall lasts exactly 1 cycle, because the next cycle ex_memread sees the bubble.
- A branch in the same cycle as a hazard: branch wins, and stall_cnt does not increment.
- A branch in the same cycle as freeze: freeze wins. The branch stays held in the frozen EX/MEM and is acted on in the release cycle.
- dmem_req & dmem_ready in the same cycle: no freeze.

## Structure
- Shared package pipe_pkg holds:
  - the state enum {RUN, WAIT}
  - XZR_IDX = 5'd31
  - the REG_IDX_W = 5 constant
- One sub-module, sat_counter (parameter W, inc, clear): used for stall_cnt and flush_cnt.
- The hazard comparator stays inline.

## Test plan
- LDUR X1 in EX (ex_memread=1, ex_rd=1); ID ADD using id_rn=1 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1. Next cycle normal.
- Same stimulus with ex_rd=31, id_rn=31 → no stall; stall_cnt stays 0.
- mem_branch_taken=1 together with a hazard → ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- dmem_req=1 with dmem_ready low for 3 cycles, then high → mem_wait=1 and all enables 0 for 3 cycles; release cycle normal; stall_cnt=3.
- MEM_TIMEOUT=4, dmem_ready held low 10 cycles → mem_err rises after the 5th WAIT cycle and stays 1 after release; reset_n pulse clears it.
- Assert reset_n=0 mid-WAIT → outputs take reset values asynchronously; after release state is RUN; with CNT_W=2, 5 hazards leave stall_cnt=3 (saturated).
